fir_coeff_loader: RTL and testbench

//   Serial (SPI-mode-0-like) port that writes and reads back the tap coefficients of the 4-tap FIR datapath.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/sync_edge.sv | 29 ++
 rtl/fir_coeff_loader.sv | 152 +++++++++++++++
 tb/tb_fir_coeff_loader.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants, header field layout and state encoding for the FIR coefficient loader.
package fir_pkg;

  localparam int NTAPS = 4;
  localparam int CW    = 8;
  localparam logic [NTAPS*CW-1:0] RST_COEFFS = 32'h061C1C06;

  localparam int HDR_WR     = 7;
  localparam int HDR_RSV_LO = 4;
  localparam int RSV_W      = 3;
  localparam int HDR_TAP_LO = 2;
  localparam int TAP_W      = 2;
  localparam int HDR_CNT_LO = 0;
  localparam int CNT_W      = 2;

  typedef enum logic [2:0] {IDLE, HDR, DATA, DONE, ERR} state_t;

  typedef logic [CW-1:0] coef_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin with single-cycle rise/fall pulses.
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      last  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      last  <= chain[STAGES-1];
    end
  end

  assign rise = chain[STAGES-1] & ~last;
  assign fall = ~chain[STAGES-1] & last;

endmodule

// File: rtl/fir_coeff_loader.sv
// Serial write/read-back port for the FIR tap coefficients; writes land in a shadow set
// and are committed atomically when a well-formed write frame ends.
module fir_coeff_loader #(
  parameter int NTAPS       = 4,
  parameter int CW          = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NTAPS*CW-1:0] RST_COEFFS = 32'h061C1C06
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic [NTAPS*CW-1:0] coeffs,
  output logic                coeff_upd,
  output logic                frame_err
);

  import fir_pkg::*;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic cs_start, cs_end;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  state_t state, nxt;
  logic [2:0]       bit_cnt;
  logic [CW-1:0]    shift, tx, byte_in;
  logic             is_write;
  logic [TAP_W-1:0] tap, tap_nxt;
  logic [CNT_W-1:0] left;
  logic [NTAPS-1:0][CW-1:0] active, shadow;
  logic bit_in, hdr_done, data_byte, commit, discard, reload, oe;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .din(sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .clk(clk), .rst_n(rst_n), .din(cs_n), .rise(cs_rise), .fall(cs_fall)
  );

  // A fall and rise seen together is a glitch and starts/ends nothing.
  assign cs_start = cs_fall & ~cs_rise;
  assign cs_end   = cs_rise & ~cs_fall;
  assign mosi_s   = mosi_sync[SYNC_STAGES-1];
  assign byte_in  = {shift[CW-2:0], mosi_s};
  assign tap_nxt  = tap + 1'b1;
  assign coeffs   = active;
  assign miso_oe  = oe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (!ena) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (cs_start) nxt = HDR;
        HDR: begin
          if (cs_end) nxt = IDLE;
          else if (sclk_rise && bit_cnt == 3'd7)
            nxt = (byte_in[HDR_RSV_LO +: RSV_W] != '0) ? ERR : DATA;
        end
        DATA: begin
          if (cs_end) nxt = IDLE;
          else if (sclk_rise && bit_cnt == 3'd7 && left == '0) nxt = DONE;
        end
        DONE: begin
          if (cs_end) nxt = IDLE;
          else if (sclk_rise) nxt = ERR;
        end
        ERR:     if (cs_end) nxt = IDLE;
        default: nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bit_in    = 1'b0;
    hdr_done  = 1'b0;
    data_byte = 1'b0;
    commit    = 1'b0;
    discard   = 1'b0;
    reload    = 1'b1;
    if (ena) begin
      bit_in    = sclk_rise && !cs_end && (state == HDR || state == DATA);
      hdr_done  = bit_in && state == HDR && bit_cnt == 3'd7;
      data_byte = bit_in && state == DATA && bit_cnt == 3'd7;
      commit    = cs_end && state == DONE && is_write;
      discard   = cs_end && (state == HDR || state == DATA || state == ERR);
      reload    = discard;
    end
    oe = !is_write && (state == DATA || state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      tx        <= '0;
      is_write  <= 1'b0;
      tap       <= '0;
      left      <= '0;
      active    <= RST_COEFFS;
      shadow    <= RST_COEFFS;
      miso      <= 1'b0;
      coeff_upd <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      coeff_upd <= commit;
      frame_err <= discard;
      if (commit) active <= shadow;
      // Outside a write frame the shadow always mirrors the active set.
      if (reload) shadow <= active;
      else if (data_byte && is_write) shadow[tap] <= byte_in;

      if (state == IDLE && nxt == HDR) bit_cnt <= '0;
      else if (bit_in) begin
        shift   <= byte_in;
        bit_cnt <= bit_cnt + 3'd1;
      end

      // Read data is preloaded on the byte-completing rise and shifted out on falls.
      if (hdr_done) begin
        is_write <= byte_in[HDR_WR];
        tap      <= byte_in[HDR_TAP_LO +: TAP_W];
        left     <= byte_in[HDR_CNT_LO +: CNT_W];
        tx       <= active[byte_in[HDR_TAP_LO +: TAP_W]];
      end else if (data_byte) begin
        tap  <= tap_nxt;
        left <= left - 1'b1;
        tx   <= (left == '0) ? '0 : active[tap_nxt];
      end else if (sclk_fall && oe) begin
        tx <= {tx[CW-2:0], 1'b0};
      end

      if (nxt == IDLE || nxt == ERR) miso <= 1'b0;
      else if (sclk_fall && oe) miso <= tx[CW-1];
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed and randomized frames against a behavioural coefficient model.
module tb_fir_coeff_loader;

  localparam logic [31:0] RST_C = 32'h061C1C06;

  logic clk = 1'b0;
  logic rst_n, ena, sclk, cs_n, mosi, miso, miso_oe, coeff_upd, frame_err;
  logic [31:0] coeffs;
  logic [31:0] prev_coeffs = 32'h0;

  int checks = 0;
  int errors = 0;
  int upd_cnt = 0;
  int err_cnt = 0;
  int mon_bad = 0;

  logic [7:0] model  [4];
  logic [7:0] tx_buf [8];
  logic [7:0] rx_buf [8];

  fir_coeff_loader dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .coeffs(coeffs), .coeff_upd(coeff_upd),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coeff_upd) upd_cnt++;
    if (frame_err) err_cnt++;
    if (rst_n && coeffs !== prev_coeffs && !coeff_upd) mon_bad++;
    prev_coeffs = coeffs;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_flat();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  task automatic model_reset();
    model[0] = 8'h06; model[1] = 8'h1C; model[2] = 8'h1C; model[3] = 8'h06;
  endtask

  task automatic send_byte(input logic [7:0] v, input logic exp_oe, input string tag,
                           output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = v[i];
      #80 sclk = 1'b1;
      r[i] = miso;
      if (i == 3) check({tag, "_oe"}, 32'(miso_oe), 32'(exp_oe));
      #80 sclk = 1'b0;
    end
  endtask

  // Sends tx_buf[0..nb-1] (header first) in one frame and checks it against the model.
  task automatic run_frame(input int nb, input string tag);
    logic [7:0] hdr, r;
    logic rsv, wr, bad, rd;
    int st, cnt, nd;
    logic [7:0] exp_rx [8];
    hdr = tx_buf[0];
    rsv = (hdr[6:4] != 3'd0);
    wr  = hdr[7];
    rd  = !rsv && !wr;
    st  = int'(hdr[3:2]);
    cnt = int'(hdr[1:0]) + 1;
    nd  = nb - 1;
    bad = rsv || (nd != cnt);
    for (int i = 0; i < 8; i++) exp_rx[i] = (rd && i < cnt) ? model[(st + i) % 4] : 8'h00;
    upd_cnt = 0;
    err_cnt = 0;
    cs_n = 1'b0;
    #80;
    for (int b = 0; b < nb; b++) begin
      send_byte(tx_buf[b], rd && b >= 1 && b <= cnt, tag, r);
      rx_buf[b] = r;
    end
    #80 cs_n = 1'b1;
    #200;
    if (!bad && wr) for (int i = 0; i < cnt; i++) model[(st + i) % 4] = tx_buf[1 + i];
    for (int b = 1; b < nb; b++) check({tag, "_rx"}, 32'(rx_buf[b]), 32'(exp_rx[b-1]));
    check({tag, "_upd"}, 32'(upd_cnt), (bad || !wr) ? 32'd0 : 32'd1);
    check({tag, "_err"}, 32'(err_cnt), bad ? 32'd1 : 32'd0);
    check({tag, "_coeffs"}, coeffs, model_flat());
    check({tag, "_miso_end"}, 32'(miso), 32'd0);
    check({tag, "_oe_end"}, 32'(miso_oe), 32'd0);
  endtask

  logic [7:0] r, h;
  int cnt, nd;

  initial begin
    rst_n = 1'b0; ena = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    model_reset();
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    #40;
    check("rst_coeffs", coeffs, RST_C);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_upd", 32'(coeff_upd), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);

    tx_buf[0] = 8'h83; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02; tx_buf[3] = 8'h03; tx_buf[4] = 8'h04;
    run_frame(5, "wr4");
    check("wr4_const", coeffs, 32'h04030201);

    tx_buf[0] = 8'h8D; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB;
    run_frame(3, "wrap");
    check("wrap_const", coeffs, 32'hAA0302BB);

    tx_buf[0] = 8'h83; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22;
    run_frame(3, "short");
    tx_buf[0] = 8'h81; tx_buf[1] = 8'h5A; tx_buf[2] = 8'hA5;
    run_frame(3, "recover");

    tx_buf[0] = 8'hF0; tx_buf[1] = 8'h99;
    run_frame(2, "rsv");

    // ena dropped mid-write: silent abort, frame stays dead until cs_n goes high.
    upd_cnt = 0; err_cnt = 0;
    cs_n = 1'b0;
    #80;
    send_byte(8'h83, 1'b0, "ena", r);
    send_byte(8'h11, 1'b0, "ena", r);
    ena = 1'b0;
    #200;
    ena = 1'b1;
    send_byte(8'h22, 1'b0, "ena", r);
    send_byte(8'h33, 1'b0, "ena", r);
    send_byte(8'h44, 1'b0, "ena", r);
    #80 cs_n = 1'b1;
    #200;
    check("ena_upd", 32'(upd_cnt), 32'd0);
    check("ena_err", 32'(err_cnt), 32'd0);
    check("ena_coeffs", coeffs, model_flat());

    upd_cnt = 0; err_cnt = 0;
    cs_n = 1'b0;
    #80;
    send_byte(8'h83, 1'b0, "rstmid", r);
    send_byte(8'h77, 1'b0, "rstmid", r);
    send_byte(8'h66, 1'b0, "rstmid", r);
    #40 rst_n = 1'b0;
    #20;
    check("rstmid_coeffs", coeffs, RST_C);
    check("rstmid_oe", 32'(miso_oe), 32'd0);
    cs_n = 1'b1;
    #40 rst_n = 1'b1;
    model_reset();
    #200;
    check("rstmid_upd", 32'(upd_cnt), 32'd0);
    check("rstmid_err", 32'(err_cnt), 32'd0);
    check("rstmid_after", coeffs, RST_C);

    tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
    run_frame(3, "rd2");
    check("rd2_b0", 32'(rx_buf[1]), 32'h1C);
    check("rd2_b1", 32'(rx_buf[2]), 32'h1C);

    tx_buf[0] = 8'h05; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00; tx_buf[3] = 8'h00;
    run_frame(4, "rdx");
    check("rdx_tail", 32'(rx_buf[3]), 32'h00);

    for (int k = 0; k < 24; k++) begin
      h[7]   = 1'($urandom_range(0, 1));
      h[6:4] = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      h[3:0] = 4'($urandom);
      cnt = int'(h[1:0]) + 1;
      case ($urandom_range(0, 5))
        0:       nd = cnt - 1;
        1:       nd = cnt + 1;
        default: nd = cnt;
      endcase
      tx_buf[0] = h;
      for (int i = 1; i <= nd; i++) tx_buf[i] = 8'($urandom);
      run_frame(nd + 1, "rnd");
    end

    check("upd_tracks_coeffs", 32'(mon_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
